// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, stage FSM encoding,
// and the forward / inverse S-box tables.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NCOL    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } aes_fsm_e;

    localparam logic [7:0] AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] AES_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES S-box lane, forward or inverse by table lookup.
// Shared by SubBytes and the key-schedule SubWord.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    assign out = inv ? AES_INV_SBOX[in] : AES_SBOX[in];

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Iterative SubBytes / InvSubBytes: one 32-bit column per cycle
// through four shared S-box lanes, valid/ready on both sides.
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int NCOL = AES_NCOL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam int CW = $clog2(NCOL);
    localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);

    aes_fsm_e               state_q;
    logic [CW-1:0]          col_q;
    logic                   mode_q;
    logic                   valid_q;
    logic [AES_STATE_W-1:0] data_q;
    logic [31:0]            col_in;
    logic [31:0]            col_out;
    logic                   acc;

    assign col_in = data_q[int'(col_q) * 32 +: 32];

    for (genvar r = 0; r < 4; r++) begin : g_lane
        aes_sbox u_sbox (
            .in  (col_in[8*r +: 8]),
            .inv (mode_q),
            .out (col_out[8*r +: 8])
        );
    end

    // A finished result can hand off and a new block load on one edge.
    assign in_ready = !rst &&
                      (state_q == ST_IDLE ||
                       (state_q == ST_DONE && out_ready));
    assign acc = in_valid && in_ready;

    assign out_valid = valid_q;
    assign out_state = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        data_q  <= in_state;
                        mode_q  <= in_inv;
                        col_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    data_q[int'(col_q) * 32 +: 32] <= col_out;
                    col_q <= col_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (acc) begin
                        data_q  <= in_state;
                        mode_q  <= in_inv;
                        col_q   <= '0;
                        valid_q <= 1'b0;
                        state_q <= ST_BUSY;
                    end else if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq with an independent
// GF(2^8) S-box model for the random stream.
module tb_aes_sub_bytes_seq;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    int tests = 0;
    int fails = 0;

    logic [7:0] ftab [256];
    logic [7:0] itab [256];

    localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

    aes_sub_bytes_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
               {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        for (int b = 0; b < 16; b++)
            r[8*b +: 8] = inv ? itab[s[8*b +: 8]] : ftab[s[8*b +: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] s, input logic inv,
                             output logic [127:0] res, output int lat);
        in_valid = 1'b1;
        in_state = s;
        in_inv   = inv;
        tick();
        in_valid = 1'b0;
        in_state = ~s;
        in_inv   = ~inv;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = out_state;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] hold;
        logic [127:0] blk [8];
        logic [127:0] exp_q [8];
        int lat;
        int k;
        int j;
        int cyc;
        int prev;
        logic acc;
        logic seen;

        for (int x = 0; x < 256; x++) begin
            ftab[x] = sb(8'(x));
            itab[sb(8'(x))] = 8'(x);
        end

        rst = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        in_inv = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_out_state", out_state, 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 128'(in_ready), 128'h1);

        run_block(FIPS_IN, 1'b0, res, lat);
        chk("fips_fwd", res, FIPS_OUT);
        chk("fips_fwd_lat", 128'(lat), 128'd4);
        drain();

        run_block(FIPS_OUT, 1'b1, res, lat);
        chk("fips_inv", res, FIPS_IN);
        drain();

        run_block({16{8'h63}}, 1'b1, res, lat);
        chk("all63_inv", res, 128'h0);
        drain();

        run_block({16{8'hff}}, 1'b0, res, lat);
        chk("allff_fwd", res, {16{8'h16}});

        hold = out_state;
        in_valid = 1'b1;
        in_state = FIPS_OUT;
        in_inv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_state", out_state, hold);
            chk("bp_in_ready", {126'h0, out_valid, in_ready}, 128'h2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0;
        in_state = '0;
        in_inv = 1'b0;
        out_ready = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_next_lat", 128'(lat), 128'd4);
        chk("bp_next_res", out_state, FIPS_IN);

        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 128'(out_valid), 128'h0);
        chk("async_rst_state", out_state, 128'h0);
        chk("async_rst_ready", 128'(in_ready), 128'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("async_rel_ready", 128'(in_ready), 128'h1);

        in_valid = 1'b1;
        in_state = FIPS_IN;
        in_inv = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("busy_rst_valid", 128'(out_valid), 128'h0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("busy_rst_dropped", 128'(seen), 128'h0);
        run_block(128'h0, 1'b0, res, lat);
        chk("zero_fwd", res, {16{8'h63}});
        chk("zero_fwd_lat", 128'(lat), 128'd4);
        drain();

        for (int n = 0; n < 8; n++) begin
            blk[n] = {$urandom, $urandom, $urandom, $urandom};
            exp_q[n] = ref_sub(blk[n], n[0]);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_state = blk[0];
        in_inv = 1'b0;
        k = 0;
        j = 0;
        cyc = 0;
        prev = 0;
        while (j < 8 && cyc < 100) begin
            if (out_valid) begin
                chk($sformatf("stream_res%0d", j), out_state, exp_q[j]);
                if (j > 0)
                    chk($sformatf("stream_gap%0d", j), 128'(cyc - prev), 128'd5);
                prev = cyc;
                j++;
            end
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                k++;
                if (k < 8) begin
                    in_state = blk[k];
                    in_inv = k[0];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("stream_count", 128'(j), 128'd8);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_seq.md
# aes_sub_bytes_seq

Iterative SubBytes / InvSubBytes stage for the AES datapath. It sits directly upstream of the ShiftRows stage in the encrypt round and directly downstream of the inverse-ShiftRows stage in the decrypt round. It accepts a 128-bit state over a valid/ready handshake and substitutes one 32-bit column per cycle through four shared S-box lanes. It presents the result, with the same byte layout, over a second valid/ready handshake.

## Interface
- NCOL, 4: columns per state; fixed by AES, not to be overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_state/in_inv valid.
- in_ready  out  1  block can accept.
- in_state  in  128  state; byte (row r, col c) at bits [32c+8r+7 : 32c+8r]; byte 0 at [7:0].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with in_state.
- out_valid  out  1  out_state holds a complete result.
- out_ready  in  1  downstream accepts.
- out_state  out  128  substituted state, same byte layout as in_state.

## Operation
- FSM states:
  - IDLE: waits for a block; in_ready=1.
  - BUSY: column counter col ∈ 0..3.
  - DONE: out_valid=1.
- IDLE, on in_valid & in_ready: latch in_state into the data register and in_inv into the mode flag, set col=0, go to BUSY.
- BUSY, each cycle: replace column col (bits [32col+31:32col]) in place with S(byte) for each of its 4 bytes. S is the forward or inverse table according to the latched mode flag.
  - col<3: col += 1.
  - col==3: go to DONE.
- DONE: out_valid=1. out_state must stay stable while out_ready=0.
  - On out_ready=1 with no new input: go to IDLE.
  - If in_valid is also 1, the new block is accepted on the same edge and the FSM goes straight to BUSY with col=0.
- in_ready = (IDLE) | (DONE & out_ready). in_ready is 0 in BUSY, and 0 while rst is asserted.
- in_inv is ignored except on an accepting edge. A mode change takes effect per block, never mid-block.
- Counter: 2-bit. The wrap from 3 coincides with the BUSY→DONE transition and is not otherwise observable.
- Reset (any state, including mid-BUSY): FSM→IDLE, col=0, mode=0, out_state=0, out_valid=0. A partially processed block is discarded silently.

## Timing
- Reset values: out_valid=0, out_state=128'h0, in_ready=0 during reset and 1 from the first cycle after rst deasserts.
- Latency: out_valid rises 4 cycles after the accepting edge, i.e. after 4 BUSY edges.
- Throughput: one block per 5 cycles with out_ready held high (4 BUSY cycles + 1 DONE/accept cycle).
- Backpressure: DONE persists indefinitely. No input is accepted while DONE & !out_ready.
- in_state is not required to be held after the accepting edge.
- No combinational path from in_state to out_state.
- The only combinational input-to-output path is out_ready → in_ready.

## Structure
- aes_pkg (shared with the other AES stages) holds:
  - AES_STATE_W=128, AES_NCOL=4
  - typedef for the FSM state enum
  - forward and inverse S-box constant tables (256×8 each)
- Sub-module aes_sbox: combinational, ports {in[7:0], inv, out[7:0]}, table lookup from aes_pkg. It is instantiated 4 times, one per row lane. It is reusable by the key-schedule SubWord block.

## Test plan
- Reset value check:
  - Stimulus: assert rst mid-cycle.
  - Required response: out_valid=0, out_state=0 immediately, without waiting for clk; in_ready=1 one cycle after release.
- FIPS-197 App. B, round 1, forward:
  - Stimulus: in_state bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, in_inv=0.
  - Required response: after 4 cycles out_state bytes = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
- Inverse round-trip:
  - Stimulus: feed that output with in_inv=1.
  - Required response: returns 19 3d e3 … 08.
  - Additionally, an all-0x63 state with inv=1 → all-0x00; all-0xFF with inv=0 → all-0x16.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid.
  - Required response: out_state stable, in_ready=0 throughout; on out_ready=1 with in_valid=1, the new block is accepted on the same edge and out_valid rises exactly 4 cycles later.
- Reset mid-BUSY:
  - Stimulus: assert rst with col=2.
  - Required response: no out_valid for that block; the next block (all-0x00, inv=0) yields all-0x63.
- Back-to-back stream:
  - Stimulus: 8 random blocks with alternating in_inv and out_ready=1.
  - Required response: results match the reference model in order, spaced 5 cycles apart.
